// File: rtl/prog_rate_divider.sv
// Programmable rate divider: divides inputClock_i by a runtime-loadable divisor and
// emits a 50% toggle clock, a one-cycle pulse or a one-shot level, plus a tick counter.
module prog_rate_divider #(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 inputClock_i,
    input  logic                 nReset_i,
    input  logic                 enable_i,
    input  logic                 pause_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     loadValue_i,
    input  logic [1:0]           mode_i,
    output logic                 outputClock_o,
    output logic                 tick_o,
    output logic                 busy_o,
    output logic                 loadError_o,
    output logic [CNT_WIDTH-1:0] tickCount_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_TOGGLE  = 2'b00,
        MODE_PULSE   = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    state_t               state_q,   state_d;
    mode_t                mode_q,    mode_d;
    logic [WIDTH-1:0]     counter_q, counter_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [CNT_WIDTH-1:0] count_q,   count_d;
    logic                 out_clk_q, out_clk_d;
    logic                 tick_q,    tick_d;
    logic                 busy_q,    busy_d;
    logic                 load_err_q, load_err_d;

    logic load_ok;
    logic expiry;

    assign load_ok = load_i && (loadValue_i != '0);
    // The counter is zeroed on every accepted load, so it never runs past divisor-1.
    assign expiry  = (counter_q == divisor_q - WIDTH'(1));

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        counter_d  = counter_q;
        divisor_d  = divisor_q;
        count_d    = count_q;
        out_clk_d  = out_clk_q;
        tick_d     = 1'b0;
        load_err_d = 1'b0;

        // Divisor capture is independent of the state machine and accepted everywhere.
        if (load_i) begin
            if (load_ok) divisor_d  = loadValue_i;
            else         load_err_d = 1'b1;
        end

        if (clear_i) begin
            counter_d = '0;
            count_d   = '0;
            out_clk_d = 1'b0;
        end else if (!enable_i) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            out_clk_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RUN;
                    counter_d = '0;
                    count_d   = '0;
                    mode_d    = mode_t'(mode_i);
                end
                ST_RUN: begin
                    if (load_ok) begin
                        counter_d = '0;
                    end else if (!pause_i) begin
                        if (expiry) begin
                            counter_d = '0;
                            tick_d    = 1'b1;
                            count_d   = count_q + CNT_WIDTH'(1);
                        end else begin
                            counter_d = counter_q + WIDTH'(1);
                        end
                    end
                    if (pause_i) state_d = ST_PAUSED;

                    case (mode_q)
                        MODE_TOGGLE:  if (tick_d) out_clk_d = ~out_clk_q;
                        MODE_ONESHOT: if (tick_d) begin
                            out_clk_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                        default:      out_clk_d = tick_d;
                    endcase
                end
                ST_PAUSED: begin
                    if (load_ok)  counter_d = '0;
                    if (!pause_i) state_d   = ST_RUN;
                end
                ST_DONE: begin
                    if (load_ok) counter_d = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge inputClock_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_PULSE;
            counter_q  <= '0;
            divisor_q  <= WIDTH'(DEFAULT_DIV);
            count_q    <= '0;
            out_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            counter_q  <= counter_d;
            divisor_q  <= divisor_d;
            count_q    <= count_d;
            out_clk_q  <= out_clk_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            load_err_q <= load_err_d;
        end
    end

    assign outputClock_o = out_clk_q;
    assign tick_o        = tick_q;
    assign busy_o        = busy_q;
    assign loadError_o   = load_err_q;
    assign tickCount_o   = count_q;

endmodule

// File: tb/tb_prog_rate_divider.sv
// Self-checking bench for prog_rate_divider: table vectors, directed corner sequences
// and randomized stimulus compared against a cycle-level behavioural model.
module tb_prog_rate_divider;

    localparam int WIDTH     = 8;
    localparam int DEF_DIV   = 5;
    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 pause = 1'b0;
    logic                 clear = 1'b0;
    logic                 load = 1'b0;
    logic [WIDTH-1:0]     load_value = '0;
    logic [1:0]           mode = 2'b00;
    logic                 out_clk;
    logic                 tick;
    logic                 busy;
    logic                 load_err;
    logic [CNT_WIDTH-1:0] tick_count;

    int n_checks = 0;
    int n_pass   = 0;

    prog_rate_divider #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEF_DIV),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .inputClock_i (clk),
        .nReset_i     (rst_n),
        .enable_i     (enable),
        .pause_i      (pause),
        .clear_i      (clear),
        .load_i       (load),
        .loadValue_i  (load_value),
        .mode_i       (mode),
        .outputClock_o(out_clk),
        .tick_o       (tick),
        .busy_o       (busy),
        .loadError_o  (load_err),
        .tickCount_o  (tick_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: elapsed counts completed cycles of the current period.
    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} m_state_t;
    m_state_t m_st;
    int       m_elapsed, m_div, m_mode, m_ticks;
    bit       m_level, m_tick, m_lerr;

    task automatic model_reset();
        m_st = M_IDLE; m_elapsed = 0; m_div = DEF_DIV; m_mode = 1;
        m_ticks = 0; m_level = 0; m_tick = 0; m_lerr = 0;
    endtask

    task automatic model_edge();
        bit ld_ok;
        int nd;
        ld_ok  = load && (load_value != 0);
        nd     = m_div;
        m_tick = 0;
        m_lerr = load && (load_value == 0);
        if (ld_ok) nd = int'(load_value);
        if (clear) begin
            m_elapsed = 0; m_ticks = 0; m_level = 0;
        end else if (!enable) begin
            m_st = M_IDLE; m_elapsed = 0; m_level = 0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    m_st = M_RUN; m_elapsed = 0; m_ticks = 0;
                    m_mode = (int'(mode) == 3) ? 1 : int'(mode);
                end
                M_RUN: begin
                    if (ld_ok) m_elapsed = 0;
                    else if (!pause) begin
                        m_elapsed++;
                        if (m_elapsed == m_div) begin
                            m_elapsed = 0; m_tick = 1; m_ticks++;
                        end
                    end
                    if (pause) m_st = M_PAUSED;
                    case (m_mode)
                        0:       if (m_tick) m_level = !m_level;
                        2:       if (m_tick) begin m_level = 1; m_st = M_DONE; end
                        default: m_level = m_tick;
                    endcase
                end
                M_PAUSED: begin
                    if (ld_ok) m_elapsed = 0;
                    if (!pause) m_st = M_RUN;
                end
                default: ;
            endcase
        end
        m_div = nd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_tick"}, 32'(tick), 32'(m_tick));
        check({tag, "_oclk"}, 32'(out_clk), 32'(m_level));
        check({tag, "_busy"}, 32'(busy), 32'(m_st == M_RUN || m_st == M_PAUSED));
        check({tag, "_lerr"}, 32'(load_err), 32'(m_lerr));
        check({tag, "_cnt"}, 32'(tick_count), 32'(m_ticks % (1 << CNT_WIDTH)));
    endtask

    task automatic do_reset();
        enable = 0; pause = 0; clear = 0; load = 0; load_value = '0; mode = 2'b00;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Drive one edge's inputs, clock it, advance the model, sample 1 time unit later.
    task automatic step(input bit en, input bit p, input bit c, input bit ld,
                        input logic [WIDTH-1:0] lv, input logic [1:0] md);
        enable = en; pause = p; clear = c; load = ld; load_value = lv; mode = md;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit       rst_before;
        bit       en;
        bit [1:0] md;
        bit       e_tick;
        bit       e_oc;
        bit       e_busy;
        int       e_cnt;
    } vec_t;

    vec_t vecs[38];

    initial begin
        int first;
        // Pulse mode for 17 edges, then toggle mode for 21 edges, each from reset.
        for (int i = 0; i < 17; i++)
            vecs[i] = '{rst_before: (i == 0), en: 1, md: 2'b01,
                        e_tick: (i > 0 && i % 5 == 0), e_oc: (i > 0 && i % 5 == 0),
                        e_busy: 1, e_cnt: i / 5};
        for (int i = 0; i < 21; i++)
            vecs[17 + i] = '{rst_before: (i == 0), en: 1, md: 2'b00,
                             e_tick: (i > 0 && i % 5 == 0), e_oc: ((i / 5) % 2 == 1),
                             e_busy: 1, e_cnt: i / 5};

        do_reset();
        check("reset_tick", 32'(tick), 0);
        check("reset_oclk", 32'(out_clk), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_lerr", 32'(load_err), 0);
        check("reset_cnt", 32'(tick_count), 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            step(vecs[i].en, 0, 0, 0, '0, vecs[i].md);
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].e_tick));
            check($sformatf("vec%0d_oclk", i), 32'(out_clk), 32'(vecs[i].e_oc));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_cnt", i), 32'(tick_count), 32'(vecs[i].e_cnt));
        end

        // Pause with counter at 2 for 7 cycles; the tick lands 3 edges after the release edge.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, 2'b01);
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 0, 0, '0, 2'b01);
            check("paused_tick", 32'(tick), 0);
            check("paused_busy", 32'(busy), 1);
            compare_model("paused");
        end
        first = 0;
        for (int j = 1; j <= 6; j++) begin
            step(1, 0, 0, 0, '0, 2'b01);
            compare_model("resume");
            if (tick && first == 0) first = j;
        end
        check("resume_gap", 32'(first), 4);

        // Load 3 mid-count, then a rejected zero load that leaves the period alone.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, 2'b01);
        step(1, 0, 0, 1, 8'd3, 2'b01);
        check("load3_tick", 32'(tick), 0);
        for (int j = 1; j <= 9; j++) begin
            step(1, 0, 0, (j == 4), '0, 2'b01);
            check($sformatf("load3_j%0d_tick", j), 32'(tick), 32'(j % 3 == 0));
            check($sformatf("load3_j%0d_lerr", j), 32'(load_err), 32'(j == 4));
            compare_model("load3");
        end

        // One-shot: single tick at edge 5, level held, then released by enable=0.
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            step(1, 0, 0, 0, '0, 2'b10);
            check($sformatf("oneshot%0d_tick", i), 32'(tick), 32'(i == 5));
            check($sformatf("oneshot%0d_oclk", i), 32'(out_clk), 32'(i >= 5));
            check($sformatf("oneshot%0d_busy", i), 32'(busy), 32'(i < 5));
        end
        step(0, 0, 0, 0, '0, 2'b10);
        check("oneshot_off_oclk", 32'(out_clk), 0);
        check("oneshot_off_busy", 32'(busy), 0);
        check("oneshot_off_cnt", 32'(tick_count), 1);

        // Divisor 1: tick every cycle and tickCount wraps 15 -> 0 -> 1.
        do_reset();
        step(0, 0, 0, 1, 8'd1, 2'b01);
        for (int i = 0; i <= 17; i++) begin
            step(1, 0, 0, 0, '0, 2'b01);
            check($sformatf("div1_%0d_tick", i), 32'(tick), 32'(i > 0));
            check($sformatf("div1_%0d_cnt", i), 32'(tick_count), 32'(i % 16));
        end

        // Asynchronous reset mid-count restores outputs and the default divisor.
        step(1, 0, 0, 1, 8'd3, 2'b01);
        step(1, 0, 0, 0, '0, 2'b01);
        step(1, 0, 0, 0, '0, 2'b01);
        rst_n = 0;
        model_reset();
        enable = 0; load = 0;
        #2;
        check("async_rst_tick", 32'(tick), 0);
        check("async_rst_oclk", 32'(out_clk), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_cnt", 32'(tick_count), 0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i <= 6; i++) begin
            step(1, 0, 0, 0, '0, 2'b01);
            check($sformatf("postrst%0d_tick", i), 32'(tick), 32'(i == 5));
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            bit en, p, c, ld;
            en = ($urandom_range(0, 31) != 0);
            p  = ($urandom_range(0, 7) == 0);
            c  = en && ($urandom_range(0, 63) == 0);
            ld = !c && ($urandom_range(0, 15) == 0);
            step(en, p, c, ld, WIDTH'($urandom_range(0, 6)), 2'($urandom_range(0, 3)));
            compare_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
